// File: rtl/core_test_monitor.sv
// core_test_monitor
//   Pass/fail monitor for RISC-V core regression programs. It snoops the core's
//   register-file writeback port and keeps a shadow copy of NUM_CHECKS selected
//   registers. A run is graded against CHECK_VALUES in one of two cases:
//     - TEST_LENGTH cycles have passed since start.
//     - EARLY_EXIT is set and the run has been quiet for QUIET_CYCLES cycles
//       while every check already matched. Quiet means no writeback at all.
//
// Ports
//   clock, reset  system clock; synchronous, active-high reset
//   start         1-cycle pulse; starts a run from IDLE or DONE, ignored otherwise
//   wb_enable     register-file write strobe
//   wb_address    destination register of the writeback
//   wb_data       writeback data
//   busy          run in progress (RUN and GRADE states)
//   done          grading complete, held until start/reset
//   pass, fail    grading verdict, held until start/reset
//   fail_index    lowest-numbered mismatching check, 0 on pass
//   early         grading was triggered by quiescence rather than the budget
//   cycle_count   RUN cycles elapsed, frozen after grading
//
// Handshake: start is a level sampled on the rising clock edge. It has no
// ready. It takes effect only when the FSM is in IDLE or DONE.
// The FSM state is visible as the internal signal `state` for checkers.
module core_test_monitor #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_INDEX_BITS = 5,
  parameter int NUM_CHECKS     = 4,
  parameter int CHECK_IDX_BITS = 2,
  parameter int CYCLE_BITS     = 20,
  parameter int TEST_LENGTH    = 10000,
  parameter logic [NUM_CHECKS*REG_INDEX_BITS-1:0] CHECK_REGS   = {5'd9, 15'd0},
  parameter logic [NUM_CHECKS*DATA_WIDTH-1:0]     CHECK_VALUES = {32'h0000000f, 96'd0},
  parameter int EARLY_EXIT     = 1,
  parameter int QUIET_CYCLES   = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      wb_enable,
  input  logic [REG_INDEX_BITS-1:0] wb_address,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic [CHECK_IDX_BITS-1:0] fail_index,
  output logic                      early,
  output logic [CYCLE_BITS-1:0]     cycle_count
);

  localparam int QB = $clog2(QUIET_CYCLES + 1);
  localparam logic [CYCLE_BITS-1:0] LAST_CYCLE = CYCLE_BITS'(TEST_LENGTH - 1);
  localparam logic [QB-1:0]         QUIET_MAX  = QB'(QUIET_CYCLES);

  // Elaboration-time parameter checks. cycle_count must never wrap.
  if (TEST_LENGTH < 1 || longint'(TEST_LENGTH) >= (longint'(1) << CYCLE_BITS)) begin : g_bad_length
    $error("core_test_monitor: TEST_LENGTH must be in 1..2^CYCLE_BITS-1");
  end
  if (NUM_CHECKS < 1 || NUM_CHECKS > 16) begin : g_bad_checks
    $error("core_test_monitor: NUM_CHECKS must be in 1..16");
  end
  if (CHECK_IDX_BITS < 1 || (1 << CHECK_IDX_BITS) < NUM_CHECKS) begin : g_bad_idx_bits
    $error("core_test_monitor: CHECK_IDX_BITS too small for NUM_CHECKS");
  end
  if (QUIET_CYCLES < 1) begin : g_bad_quiet
    $error("core_test_monitor: QUIET_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_GRADE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]     shadow [NUM_CHECKS];
  logic [NUM_CHECKS-1:0]     match;
  logic [CHECK_IDX_BITS-1:0] first_fail;
  logic [QB-1:0]             quiet, quiet_next;
  logic                      start_accept;
  logic                      timeout;
  logic                      quiet_hit;

  // Compare each shadow against its expected value. A shadow that was never
  // loaded stays 0, which matches a zero-initialised register file.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      match[k] = (shadow[k] == CHECK_VALUES[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Scan from the top down so that the lowest mismatching index wins.
  always_comb begin
    first_fail = '0;
    for (int k = NUM_CHECKS - 1; k >= 0; k--) begin
      if (!match[k]) first_fail = CHECK_IDX_BITS'(k);
    end
  end

  // A write to x0 also counts as activity and resets the quiet counter.
  always_comb begin
    if (wb_enable || !(&match))  quiet_next = '0;
    else if (quiet == QUIET_MAX) quiet_next = quiet;
    else                         quiet_next = quiet + 1'b1;
  end

  assign start_accept = start && (state == S_IDLE || state == S_DONE);
  assign timeout      = (cycle_count == LAST_CYCLE);
  assign quiet_hit    = (EARLY_EXIT != 0) && (quiet_next == QUIET_MAX);

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (timeout || quiet_hit) state_next = S_GRADE;
      S_GRADE: state_next = S_DONE;
      S_DONE:  if (start) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from the state
  always_comb begin
    busy = (state == S_RUN) || (state == S_GRADE);
  end

  // Datapath: shadows, counters and the held verdict
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_CHECKS; k++) shadow[k] <= '0;
      quiet       <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_index  <= '0;
      early       <= 1'b0;
    end else if (start_accept) begin
      for (int k = 0; k < NUM_CHECKS; k++) shadow[k] <= '0;
      quiet       <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_index  <= '0;
      early       <= 1'b0;
    end else if (state == S_RUN) begin
      cycle_count <= cycle_count + 1'b1;
      quiet       <= quiet_next;
      // Duplicate check indices load together. A write in the timeout cycle
      // is captured here and is seen by GRADE in the next cycle.
      for (int k = 0; k < NUM_CHECKS; k++) begin
        if (wb_enable && wb_address != '0 &&
            wb_address == CHECK_REGS[k*REG_INDEX_BITS +: REG_INDEX_BITS]) begin
          shadow[k] <= wb_data;
        end
      end
      // If timeout and quiescence fall in the same cycle, the budget wins.
      if (quiet_hit && !timeout) early <= 1'b1;
    end else if (state == S_GRADE) begin
      done       <= 1'b1;
      pass       <= &match;
      fail       <= ~(&match);
      fail_index <= (&match) ? '0 : first_fail;
    end
  end

endmodule

// File: tb/tb_core_test_monitor.sv
// Testbench for core_test_monitor. It uses three instances on shared stimulus:
//   dut_a : default parameters with EARLY_EXIT=0 (budget-only grading)
//   dut_b : two checks, check0=x9 expects 0xF, check1=x10 expects 0x5,
//           TEST_LENGTH=300, QUIET_CYCLES=8, early exit enabled
//   dut_c : default parameters (early exit, QUIET_CYCLES=64)
// In the default packing, checks 0..2 watch x0 and expect 0, and check 3 watches x9.
// So a bad x9 shows up as fail_index 3.
module tb_core_test_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        wb_enable;
  logic [4:0]  wb_address;
  logic [31:0] wb_data;

  logic a_busy, a_done, a_pass, a_fail, a_early;
  logic [1:0]  a_idx;
  logic [19:0] a_cnt;
  logic b_busy, b_done, b_pass, b_fail, b_early;
  logic [0:0]  b_idx;
  logic [19:0] b_cnt;
  logic c_busy, c_done, c_pass, c_fail, c_early;
  logic [1:0]  c_idx;
  logic [19:0] c_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  core_test_monitor #(.EARLY_EXIT(0)) dut_a (
    .clock(clock), .reset(reset), .start(start), .wb_enable(wb_enable),
    .wb_address(wb_address), .wb_data(wb_data), .busy(a_busy), .done(a_done),
    .pass(a_pass), .fail(a_fail), .fail_index(a_idx), .early(a_early),
    .cycle_count(a_cnt)
  );

  core_test_monitor #(
    .NUM_CHECKS(2), .CHECK_IDX_BITS(1), .TEST_LENGTH(300),
    .CHECK_REGS({5'd10, 5'd9}), .CHECK_VALUES({32'h5, 32'hf}),
    .EARLY_EXIT(1), .QUIET_CYCLES(8)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start), .wb_enable(wb_enable),
    .wb_address(wb_address), .wb_data(wb_data), .busy(b_busy), .done(b_done),
    .pass(b_pass), .fail(b_fail), .fail_index(b_idx), .early(b_early),
    .cycle_count(b_cnt)
  );

  core_test_monitor dut_c (
    .clock(clock), .reset(reset), .start(start), .wb_enable(wb_enable),
    .wb_address(wb_address), .wb_data(wb_data), .busy(c_busy), .done(c_done),
    .pass(c_pass), .fail(c_fail), .fail_index(c_idx), .early(c_early),
    .cycle_count(c_cnt)
  );

  // Output selector so that one set of checks can serve every instance.
  int          sel;
  logic        s_busy, s_done, s_pass, s_fail, s_early;
  logic [1:0]  s_idx;
  logic [19:0] s_cnt;

  always_comb begin
    case (sel)
      1: begin
        s_busy = b_busy; s_done = b_done; s_pass = b_pass; s_fail = b_fail;
        s_early = b_early; s_idx = {1'b0, b_idx}; s_cnt = b_cnt;
      end
      2: begin
        s_busy = c_busy; s_done = c_done; s_pass = c_pass; s_fail = c_fail;
        s_early = c_early; s_idx = c_idx; s_cnt = c_cnt;
      end
      default: begin
        s_busy = a_busy; s_done = a_done; s_pass = a_pass; s_fail = a_fail;
        s_early = a_early; s_idx = a_idx; s_cnt = a_cnt;
      end
    endcase
  end

  // ---------------- vectors ----------------
  typedef struct {
    string       name;
    int          sel;
    int          c0;      // run cycle of first write, -1 = none
    logic [4:0]  a0;
    logic [31:0] d0;
    int          c1;      // run cycle of second write, -1 = none
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        e_pass;
    logic        e_fail;
    logic [1:0]  e_idx;
    logic        e_early;
    int          e_count; // final cycle_count; done must appear one cycle later
  } vec_t;

  vec_t vecs[7];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    start = 1'b0; wb_enable = 1'b0; wb_address = '0; wb_data = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Starts a run without resetting, applies the writes, then waits for done.
  // t is the run cycle being driven: cycle_count equals t while t is in RUN.
  task automatic run_vec(input vec_t v);
    int t;
    string n;
    n = v.name;
    sel = v.sel;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({n, " busy_at_start"}, 32'(s_busy), 32'd1);
    chk({n, " cleared_at_start"}, {s_done, s_pass, s_fail, s_early, 8'(s_idx), 20'(s_cnt)}, 32'd0);
    t = 0;
    while (!s_done && t < v.e_count + 50) begin
      wb_enable = 1'b0; wb_address = '0; wb_data = '0;
      if (t == v.c0) begin wb_enable = 1'b1; wb_address = v.a0; wb_data = v.d0; end
      if (t == v.c1) begin wb_enable = 1'b1; wb_address = v.a1; wb_data = v.d1; end
      tick();
      t++;
    end
    wb_enable = 1'b0; wb_address = '0; wb_data = '0;
    chk({n, " done_seen"}, 32'(s_done), 32'd1);
    chk({n, " done_latency"}, 32'(t), 32'(v.e_count + 1));
    chk({n, " busy_after"}, 32'(s_busy), 32'd0);
    chk({n, " pass"}, 32'(s_pass), 32'(v.e_pass));
    chk({n, " fail"}, 32'(s_fail), 32'(v.e_fail));
    chk({n, " fail_index"}, 32'(s_idx), 32'(v.e_idx));
    chk({n, " early"}, 32'(s_early), 32'(v.e_early));
    chk({n, " cycle_count"}, 32'(s_cnt), 32'(v.e_count));
    tick();
    tick();
    chk({n, " held"}, {s_done, s_pass, 8'(s_idx), 20'(s_cnt)},
        {1'b1, v.e_pass, 8'(v.e_idx), 20'(v.e_count)});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    sel = 0;
    //          name          sel  c0  a0     d0          c1    a1     d1          pass  fail  idx   early  count
    vecs[0] = '{"t1_budget",   0,  -1, 5'd0,  32'h0,      100,  5'd9,  32'hf,      1'b1, 1'b0, 2'd0, 1'b0,  10000};
    vecs[1] = '{"t2_bad_x9",   0,  -1, 5'd0,  32'h0,      100,  5'd9,  32'he,      1'b0, 1'b1, 2'd3, 1'b0,  10000};
    vecs[2] = '{"t5_last_cyc", 0,   5, 5'd0,  32'hdead,   9999, 5'd9,  32'hf,      1'b1, 1'b0, 2'd0, 1'b0,  10000};
    vecs[3] = '{"t4_early",    2,  -1, 5'd0,  32'h0,      10,   5'd9,  32'hf,      1'b1, 1'b0, 2'd0, 1'b1,  75};
    vecs[4] = '{"t3_fail",     1,   3, 5'd10, 32'h5,      20,   5'd9,  32'h7,      1'b0, 1'b1, 2'd0, 1'b0,  300};
    vecs[5] = '{"coincide",    1,   3, 5'd10, 32'h5,      291,  5'd9,  32'hf,      1'b1, 1'b0, 2'd0, 1'b0,  300};
    vecs[6] = '{"quiet_first", 1,   3, 5'd10, 32'h5,      290,  5'd9,  32'hf,      1'b1, 1'b0, 2'd0, 1'b1,  299};

    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      chk($sformatf("reset_state_%0d", s),
          {s_busy, s_done, s_pass, s_fail, s_early, 7'(s_idx), 20'(s_cnt)}, 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      do_reset();
      run_vec(vecs[i]);
    end

    // Restart from DONE without reset. The old x10 shadow must be cleared, so
    // check1 fails. Then a full rerun passes via quiescence.
    do_reset();
    run_vec(vecs[4]);
    run_vec('{"t3_rerun_x9", 1, -1, 5'd0, 32'h0, 4, 5'd9, 32'hf,
              1'b0, 1'b1, 2'd1, 1'b0, 300});
    run_vec('{"t3_rerun_all", 1, 2, 5'd10, 32'h5, 4, 5'd9, 32'hf,
              1'b1, 1'b0, 2'd0, 1'b1, 13});

    // T6: start mid-run is ignored, and reset mid-run clears everything.
    do_reset();
    sel = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 500; t++) begin
      start = (t == 200);
      tick();
      if (t == 299) chk("t6_start_ignored", 32'(s_cnt), 32'd300);
    end
    start = 1'b0;
    chk("t6_busy_mid", 32'(s_busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_reset_outputs",
        {s_busy, s_done, s_pass, s_fail, s_early, 7'(s_idx), 20'(s_cnt)}, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("t6_idle_after", {s_busy, 11'd0, 20'(s_cnt)}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
